// File: rtl/dbus_ram_responder_if.sv
// Data-bus bundle between the pipeline memory stage (master) and a RAM responder (slave).
interface dbus_ram_responder_if;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_data_wr;
  logic [3:0]  dbus_be;
  logic        dbus_rd;
  logic        dbus_wr;
  logic [31:0] dbus_data_rd;
  logic        dbus_data_ready;
  logic        dbus_err;

  modport master (
    output dbus_addr, dbus_data_wr, dbus_be, dbus_rd, dbus_wr,
    input  dbus_data_rd, dbus_data_ready, dbus_err
  );

  modport slave (
    input  dbus_addr, dbus_data_wr, dbus_be, dbus_rd, dbus_wr,
    output dbus_data_rd, dbus_data_ready, dbus_err
  );
endinterface

// File: rtl/dbus_ram_responder.sv
// Word-organised data RAM answering dbus loads/stores after WAIT_STATES cycles with a
// one-cycle ready pulse; illegal requests complete with dbus_err and leave the RAM untouched.
module dbus_ram_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  dbus_ram_responder_if.slave   bus,
  output logic                  busy
);

  localparam int unsigned IdxW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WindowBytes = 32'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        turn_q, turn_d;
  logic        latch, enter_resp;

  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        rd_q, wr_q;

  logic [31:0] cur_addr, cur_wdata, offset;
  logic [3:0]  cur_be;
  logic        cur_rd, cur_wr, bad, mem_we;
  logic [IdxW-1:0] idx;

  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the access happens on the accepting edge, before the latch settles.
  always_comb begin
    if (state_q == StIdle) begin
      cur_addr  = bus.dbus_addr;
      cur_wdata = bus.dbus_data_wr;
      cur_be    = bus.dbus_be;
      cur_rd    = bus.dbus_rd;
      cur_wr    = bus.dbus_wr;
    end else begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
      cur_rd    = rd_q;
      cur_wr    = wr_q;
    end
  end

  assign offset = cur_addr - BASE_ADDR;
  assign idx    = offset[IdxW+1:2];
  assign bad    = (cur_rd & cur_wr) | (cur_addr[1:0] != 2'b00) | (cur_addr < BASE_ADDR) |
                  (offset >= WindowBytes);

  // turn_q blocks acceptance for one idle cycle after a response and after reset.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch      = 1'b0;
    enter_resp = 1'b0;
    turn_d     = (state_q == StResp);
    unique case (state_q)
      StIdle: begin
        if (!turn_q && (bus.dbus_rd || bus.dbus_wr)) begin
          latch = 1'b1;
          cnt_d = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem_we  = enter_resp && !bad && cur_wr;
  assign rdata_d = (enter_resp && !bad && cur_rd) ? mem[idx] : 32'h0;
  assign err_d   = enter_resp && bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      turn_q  <= 1'b1;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (latch) begin
        addr_q  <= bus.dbus_addr;
        wdata_q <= bus.dbus_data_wr;
        be_q    <= bus.dbus_be;
        rd_q    <= bus.dbus_rd;
        wr_q    <= bus.dbus_wr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  assign bus.dbus_data_ready = (state_q == StResp);
  assign bus.dbus_err        = err_q;
  assign bus.dbus_data_rd    = rdata_q;
  assign busy                = (state_q != StIdle);

endmodule

// File: tb/tb_dbus_ram_responder.sv
// Drives one stimulus stream into a 2-wait-state and a 0-wait-state responder and compares
// both against a transaction-level model every cycle, plus directed scenario checks.
module tb_dbus_ram_responder;

  localparam longint Base  = 64'h0001_0000;
  localparam int     Depth = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        rd, wr;
  logic        busy_w2, busy_w0;

  dbus_ram_responder_if bus_w2 ();
  dbus_ram_responder_if bus_w0 ();

  assign bus_w2.dbus_addr    = addr;
  assign bus_w2.dbus_data_wr = wdata;
  assign bus_w2.dbus_be      = be;
  assign bus_w2.dbus_rd      = rd;
  assign bus_w2.dbus_wr      = wr;
  assign bus_w0.dbus_addr    = addr;
  assign bus_w0.dbus_data_wr = wdata;
  assign bus_w0.dbus_be      = be;
  assign bus_w0.dbus_rd      = rd;
  assign bus_w0.dbus_wr      = wr;

  dbus_ram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(2)) u_dut_w2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w2),
    .busy  (busy_w2)
  );

  dbus_ram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(0)) u_dut_w0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w0),
    .busy  (busy_w0)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Transaction model: index 0 is the 2-wait-state build, index 1 the 0-wait-state build.
  int          wait_of  [2] = '{2, 0};
  bit          pend     [2];
  int          resp_cyc [2];
  int          free_cyc [2];
  logic [31:0] la [2], ld [2];
  logic [3:0]  lbe [2];
  logic        lrd [2], lwr [2];
  logic [31:0] mdl_mem [2][Depth];
  bit          mdl_ok  [2][Depth];
  logic        exp_ready [2], exp_err [2], exp_busy [2];
  logic [31:0] exp_data [2];
  bit          data_known [2];

  logic [31:0] last_data [2];
  logic        last_err  [2];
  int          rdy_q0 [$];
  int          rdy_q1 [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge(input int d, input int c);
    longint a;
    int     ix;
    bit     bad;
    if (reset) begin
      pend[d]       = 1'b0;
      free_cyc[d]   = c + 2;
      exp_ready[d]  = 1'b0;
      exp_err[d]    = 1'b0;
      exp_busy[d]   = 1'b0;
      exp_data[d]   = 32'h0;
      data_known[d] = 1'b1;
      return;
    end
    if (pend[d] && resp_cyc[d] == c) pend[d] = 1'b0;
    if (!pend[d] && c >= free_cyc[d] && (rd || wr)) begin
      pend[d]     = 1'b1;
      resp_cyc[d] = c + 1 + wait_of[d];
      free_cyc[d] = resp_cyc[d] + 2;
      la[d] = addr; ld[d] = wdata; lbe[d] = be; lrd[d] = rd; lwr[d] = wr;
    end
    exp_busy[d]   = pend[d];
    exp_ready[d]  = pend[d] && (resp_cyc[d] == c + 1);
    exp_err[d]    = 1'b0;
    exp_data[d]   = 32'h0;
    data_known[d] = 1'b1;
    if (exp_ready[d]) begin
      a   = longint'(la[d]);
      bad = (lrd[d] && lwr[d]) || (a % 4 != 0) || (a < Base) || (a >= Base + 4 * Depth);
      exp_err[d] = bad;
      if (!bad) begin
        ix = int'((a - Base) / 4);
        if (lwr[d]) begin
          for (int i = 0; i < 4; i++)
            if (lbe[d][i]) mdl_mem[d][ix][8*i +: 8] = ld[d][8*i +: 8];
          if (lbe[d] == 4'hF) mdl_ok[d][ix] = 1'b1;
        end else begin
          exp_data[d]   = mdl_mem[d][ix];
          data_known[d] = mdl_ok[d][ix];
        end
      end
    end
  endtask

  task automatic sample_and_check();
    logic r, e, b;
    logic [31:0] dt;
    string p;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        r = bus_w2.dbus_data_ready; e = bus_w2.dbus_err; dt = bus_w2.dbus_data_rd; b = busy_w2;
        p = "w2";
      end else begin
        r = bus_w0.dbus_data_ready; e = bus_w0.dbus_err; dt = bus_w0.dbus_data_rd; b = busy_w0;
        p = "w0";
      end
      if (reset) begin
        check_val({p, "_rst_ready"}, 32'(r), 32'h0);
        check_val({p, "_rst_err"}, 32'(e), 32'h0);
        check_val({p, "_rst_data"}, dt, 32'h0);
        check_val({p, "_rst_busy"}, 32'(b), 32'h0);
      end else begin
        check_val({p, "_ready"}, 32'(r), 32'(exp_ready[d]));
        check_val({p, "_err"}, 32'(e), 32'(exp_err[d]));
        check_val({p, "_busy"}, 32'(b), 32'(exp_busy[d]));
        if (data_known[d]) check_val({p, "_data"}, dt, exp_data[d]);
      end
      if (r) begin
        last_data[d] = dt;
        last_err[d]  = e;
        if (d == 0) rdy_q0.push_back(cyc);
        else        rdy_q1.push_back(cyc);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0, cyc);
    model_edge(1, cyc);
    cyc++;
    @(negedge clk);
    sample_and_check();
  endtask

  function automatic int rdy_at(input int d, input int k, input int n0);
    if (d == 0) return (rdy_q0.size() > k) ? rdy_q0[k] - n0 : -1;
    return (rdy_q1.size() > k) ? rdy_q1[k] - n0 : -1;
  endfunction

  int n0;

  task automatic xfer(input logic r, input logic w, input logic [31:0] a, input logic [31:0] dv,
                      input logic [3:0] b, input int hold);
    rdy_q0.delete();
    rdy_q1.delete();
    n0 = cyc;
    addr = a; wdata = dv; be = b; rd = r; wr = w;
    repeat (hold) tick();
    rd = 1'b0; wr = 1'b0;
    repeat (3) tick();
  endtask

  int pool [7] = '{0, 1, 2, 3, 4, 1022, 1023};

  initial begin
    reset = 1'b1;
    addr = 32'h0; wdata = 32'h0; be = 4'h0; rd = 1'b0; wr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      pend[d] = 1'b0; free_cyc[d] = 0; resp_cyc[d] = 0;
      exp_ready[d] = 1'b0; exp_err[d] = 1'b0; exp_busy[d] = 1'b0;
      exp_data[d] = 32'h0; data_known[d] = 1'b1;
      for (int i = 0; i < Depth; i++) begin
        mdl_mem[d][i] = 32'h0;
        mdl_ok[d][i]  = 1'b0;
      end
    end
    @(negedge clk);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    foreach (pool[k]) xfer(1'b0, 1'b1, 32'(Base + 4 * pool[k]), 32'hA5A5_0000 | 32'(pool[k]),
                           4'hF, 4);

    // Store/load round trip and first-response latency.
    xfer(1'b0, 1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF, 4);
    check_val("t1_lat_w2", 32'(rdy_at(0, 0, n0)), 32'd3);
    check_val("t1_lat_w0", 32'(rdy_at(1, 0, n0)), 32'd1);
    check_val("t1_err", 32'(last_err[0]), 32'h0);
    xfer(1'b1, 1'b0, 32'h0001_0010, 32'h0, 4'h0, 4);
    check_val("t1_load_w2", last_data[0], 32'hDEAD_BEEF);
    check_val("t1_load_w0", last_data[1], 32'hDEAD_BEEF);

    xfer(1'b0, 1'b1, 32'h0001_0010, 32'h1122_3344, 4'b0101, 4);
    xfer(1'b1, 1'b0, 32'h0001_0010, 32'h0, 4'h0, 4);
    check_val("t2_merge_w2", last_data[0], 32'hDE22_BE44);
    check_val("t2_merge_w0", last_data[1], 32'hDE22_BE44);

    xfer(1'b1, 1'b0, 32'h0001_0002, 32'h0, 4'h0, 4);
    check_val("t3_misalign_err", 32'(last_err[0]), 32'h1);
    check_val("t3_misalign_data", last_data[0], 32'h0);
    xfer(1'b0, 1'b1, 32'h0001_1000, 32'hFFFF_FFFF, 4'hF, 4);
    check_val("t3_range_err", 32'(last_err[0]), 32'h1);
    xfer(1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 4);
    check_val("t3_word0_kept", last_data[0], 32'hA5A5_0000);
    xfer(1'b1, 1'b1, 32'h0001_0010, 32'h0, 4'hF, 4);
    check_val("t3_rdwr_err_w2", 32'(last_err[0]), 32'h1);
    check_val("t3_rdwr_err_w0", 32'(last_err[1]), 32'h1);

    xfer(1'b1, 1'b0, 32'h0001_0010, 32'h0, 4'h0, 10);
    check_val("t4_pulse0", 32'(rdy_at(1, 0, n0)), 32'd1);
    check_val("t4_pulse1", 32'(rdy_at(1, 1, n0)), 32'd4);
    check_val("t4_pulse2", 32'(rdy_at(1, 2, n0)), 32'd7);

    // Reset lands while the 2-wait-state build is still waiting.
    rdy_q0.delete();
    rd = 1'b0; wr = 1'b1; addr = 32'h0001_0000; wdata = 32'h1234_5678; be = 4'hF;
    tick();
    reset = 1'b1; wr = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check_val("t5_no_ready", 32'(rdy_q0.size()), 32'h0);
    xfer(1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 4);
    check_val("t5_kept_w2", last_data[0], 32'hA5A5_0000);
    check_val("t5_commit_w0", last_data[1], 32'h1234_5678);

    xfer(1'b0, 1'b1, 32'h0001_0FFC, 32'hCAFE_F00D, 4'hF, 4);
    xfer(1'b1, 1'b0, 32'h0001_0FFC, 32'h0, 4'h0, 2);
    check_val("t6_lat_w0", 32'(rdy_at(1, 0, n0)), 32'd1);
    check_val("t6_last_w0", last_data[1], 32'hCAFE_F00D);
    xfer(1'b1, 1'b0, 32'h0001_1000, 32'h0, 4'h0, 2);
    check_val("t6_past_err_w0", 32'(last_err[1]), 32'h1);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(3) == 0) begin
        int sel, op;
        sel = $urandom_range(9);
        op  = $urandom_range(9);
        if (sel <= 5)      addr = 32'(Base + 4 * pool[$urandom_range(6)]);
        else if (sel == 6) addr = 32'(Base + 4 * pool[$urandom_range(6)]) + 32'($urandom_range(1, 3));
        else if (sel == 7) addr = 32'(Base + 4 * Depth) + 32'(4 * $urandom_range(3));
        else if (sel == 8) addr = 32'(Base) - 32'(4 * $urandom_range(1, 3));
        else               addr = $urandom;
        wdata = $urandom;
        be    = 4'($urandom_range(15));
        rd    = (op < 4) || (op == 8);
        wr    = (op >= 4 && op < 8) || (op == 8);
      end
      if ($urandom_range(299) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
